// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer loader.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package layer_pkg;

    // Load sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_W,
        S_B,
        S_X,
        S_HOLD
    } layer_load_state_t;

    localparam int DefaultInN       = 16;
    localparam int DefaultOutN      = 8;
    localparam int DefaultDataWidth = `DATA_WIDTH;

    // Total number of weight words for a layer.
    function automatic int weight_words(input int out_n, input int in_n);
        return out_n * in_n;
    endfunction

endpackage

// File: rtl/layer_loader.sv
// Layer loader: assembles a serial word stream into packed weight, bias and
// input-vector buses and holds them until the consumer acknowledges.
module layer_loader
    import layer_pkg::*;
#(
    parameter int IN_N       = DefaultInN,
    parameter int OUT_N      = DefaultOutN,
    parameter int DATA_WIDTH = DefaultDataWidth
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                reload_params,
    input  logic signed [DATA_WIDTH-1:0]        in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [OUT_N*IN_N*DATA_WIDTH-1:0]    weights,
    output logic [OUT_N*DATA_WIDTH-1:0]         biases,
    output logic [IN_N*DATA_WIDTH-1:0]          in_vec,
    output logic                                vec_valid,
    input  logic                                vec_ack,
    output logic                                params_valid,
    output logic                                busy,
    output logic                                start_err
);

    localparam int WTot  = weight_words(OUT_N, IN_N);
    // Word counter sized for the longest segment (weights).
    localparam int CNT_W = $clog2(OUT_N * IN_N + 1);

    localparam logic [CNT_W-1:0] WLast = CNT_W'(WTot - 1);
    localparam logic [CNT_W-1:0] BLast = CNT_W'(OUT_N - 1);
    localparam logic [CNT_W-1:0] XLast = CNT_W'(IN_N - 1);

    layer_load_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vec_valid_q, vec_valid_d;
    logic              params_valid_q, params_valid_d;
    logic              start_err_q, start_err_d;

    logic signed [DATA_WIDTH-1:0] weights_q [WTot];
    logic signed [DATA_WIDTH-1:0] biases_q  [OUT_N];
    logic signed [DATA_WIDTH-1:0] in_vec_q  [IN_N];

    logic             xfer;
    logic [WTot-1:0]  w_we;
    logic [OUT_N-1:0] b_we;
    logic [IN_N-1:0]  x_we;

    // Handshake: ready depends on state only, never on in_valid.
    always_comb begin
        in_ready = (state_q == S_W) || (state_q == S_B) || (state_q == S_X);
        xfer     = in_ready && in_valid;
        busy     = (state_q != S_IDLE);
    end

    // Sequencer next-state, counter and status flags.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        vec_valid_d    = vec_valid_q;
        params_valid_d = params_valid_q;
        start_err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reload_params) begin
                        state_d        = S_W;
                        cnt_d          = '0;
                        params_valid_d = 1'b0;
                    end else if (params_valid_q) begin
                        state_d = S_X;
                        cnt_d   = '0;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            S_W: begin
                if (xfer) begin
                    if (cnt_q == WLast) begin
                        state_d = S_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_B: begin
                if (xfer) begin
                    if (cnt_q == BLast) begin
                        state_d        = S_X;
                        cnt_d          = '0;
                        params_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_X: begin
                if (xfer) begin
                    if (cnt_q == XLast) begin
                        state_d     = S_HOLD;
                        cnt_d       = '0;
                        vec_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                // start is ignored here, even when it coincides with vec_ack.
                if (vec_ack) begin
                    state_d     = S_IDLE;
                    vec_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Slot write-enable decode: exactly one slot per accepted word.
    always_comb begin
        for (int k = 0; k < WTot; k++) begin
            w_we[k] = xfer && (state_q == S_W) && (cnt_q == CNT_W'(k));
        end
        for (int k = 0; k < OUT_N; k++) begin
            b_we[k] = xfer && (state_q == S_B) && (cnt_q == CNT_W'(k));
        end
        for (int k = 0; k < IN_N; k++) begin
            x_we[k] = xfer && (state_q == S_X) && (cnt_q == CNT_W'(k));
        end
    end

    // Sequencer state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            vec_valid_q    <= 1'b0;
            params_valid_q <= 1'b0;
            start_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            vec_valid_q    <= vec_valid_d;
            params_valid_q <= params_valid_d;
            start_err_q    <= start_err_d;
        end
    end

    // Weight slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WTot; k++) weights_q[k] <= '0;
        end else begin
            for (int k = 0; k < WTot; k++) begin
                if (w_we[k]) weights_q[k] <= in_data;
            end
        end
    end

    // Bias slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < OUT_N; k++) biases_q[k] <= '0;
        end else begin
            for (int k = 0; k < OUT_N; k++) begin
                if (b_we[k]) biases_q[k] <= in_data;
            end
        end
    end

    // Input-vector slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < IN_N; k++) in_vec_q[k] <= '0;
        end else begin
            for (int k = 0; k < IN_N; k++) begin
                if (x_we[k]) in_vec_q[k] <= in_data;
            end
        end
    end

    // Pack slot arrays onto the output buses; slot k sits at bits k*DATA_WIDTH.
    always_comb begin
        weights = '0;
        biases  = '0;
        in_vec  = '0;
        for (int k = 0; k < WTot; k++) begin
            weights[k*DATA_WIDTH +: DATA_WIDTH] = weights_q[k];
        end
        for (int k = 0; k < OUT_N; k++) begin
            biases[k*DATA_WIDTH +: DATA_WIDTH] = biases_q[k];
        end
        for (int k = 0; k < IN_N; k++) begin
            in_vec[k*DATA_WIDTH +: DATA_WIDTH] = in_vec_q[k];
        end
        vec_valid    = vec_valid_q;
        params_valid = params_valid_q;
        start_err    = start_err_q;
    end

endmodule

// File: tb/tb_layer_loader.sv
// Self-checking bench for layer_loader (IN_N=4, OUT_N=2, DATA_WIDTH=8).
module tb_layer_loader;

    localparam int IN_N  = 4;
    localparam int OUT_N = 2;
    localparam int DW    = 8;
    localparam int NW    = IN_N * OUT_N;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic                   reload_params = 1'b0;
    logic [DW-1:0]          in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NW*DW-1:0]       weights;
    logic [OUT_N*DW-1:0]    biases;
    logic [IN_N*DW-1:0]     in_vec;
    logic                   vec_valid;
    logic                   vec_ack = 1'b0;
    logic                   params_valid;
    logic                   busy;
    logic                   start_err;

    int tests = 0;
    int fails = 0;

    // Reference model: the slot contents the consumer should see.
    logic [DW-1:0] m_w [NW];
    logic [DW-1:0] m_b [OUT_N];
    logic [DW-1:0] m_x [IN_N];
    logic          m_pv;

    layer_loader #(
        .IN_N      (IN_N),
        .OUT_N     (OUT_N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .reload_params(reload_params),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .weights      (weights),
        .biases       (biases),
        .in_vec       (in_vec),
        .vec_valid    (vec_valid),
        .vec_ack      (vec_ack),
        .params_valid (params_valid),
        .busy         (busy),
        .start_err    (start_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NW*DW-1:0] exp_w();
        logic [NW*DW-1:0] r = '0;
        for (int k = 0; k < NW; k++) r[k*DW +: DW] = m_w[k];
        return r;
    endfunction

    function automatic logic [OUT_N*DW-1:0] exp_b();
        logic [OUT_N*DW-1:0] r = '0;
        for (int k = 0; k < OUT_N; k++) r[k*DW +: DW] = m_b[k];
        return r;
    endfunction

    function automatic logic [IN_N*DW-1:0] exp_x();
        logic [IN_N*DW-1:0] r = '0;
        for (int k = 0; k < IN_N; k++) r[k*DW +: DW] = m_x[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NW; k++) m_w[k] = '0;
        for (int k = 0; k < OUT_N; k++) m_b[k] = '0;
        for (int k = 0; k < IN_N; k++) m_x[k] = '0;
        m_pv = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic reload);
        start = 1'b1;
        reload_params = reload;
        tick();
        start = 1'b0;
        reload_params = 1'b0;
    endtask

    // Present one word and hold it until it is accepted (bounded).
    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_data = d;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic ack();
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
    endtask

    task automatic check_buses(input string name);
        tests++;
        if (weights !== exp_w() || biases !== exp_b() || in_vec !== exp_x()
            || params_valid !== m_pv) begin
            fails++;
            $display("FAIL %s: w=%h b=%h x=%h pv=%0b required w=%h b=%h x=%h pv=%0b", name,
                     weights, biases, in_vec, params_valid, exp_w(), exp_b(), exp_x(), m_pv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        model_clear();
        tests++;
        if ({weights, biases, in_vec, vec_valid, params_valid, in_ready, busy, start_err}
            !== '0) begin
            fails++;
            $display("FAIL reset_state: w=%h b=%h x=%h vv=%0b pv=%0b rdy=%0b busy=%0b err=%0b required all 0",
                     weights, biases, in_vec, vec_valid, params_valid, in_ready, busy,
                     start_err);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        logic [7:0] x_words [IN_N] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
        do_start(1'b1);
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_enter: busy=%0b rdy=%0b required 1 1", busy, in_ready);
        end
        for (int k = 0; k < NW; k++) begin
            send(DW'(k + 1));
            m_w[k] = DW'(k + 1);
        end
        send(8'h10);
        m_b[0] = 8'h10;
        tests++;
        if (params_valid !== 1'b0) begin
            fails++;
            $display("FAIL pv_early: params_valid=%0b required 0", params_valid);
        end
        send(8'h11);
        m_b[1] = 8'h11;
        m_pv = 1'b1;
        tests++;
        if (params_valid !== 1'b1) begin
            fails++;
            $display("FAIL pv_rise: params_valid=%0b required 1", params_valid);
        end
        for (int k = 0; k < IN_N; k++) begin
            if (k == IN_N - 1) begin
                tests++;
                if (vec_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL vv_early: vec_valid=%0b required 0", vec_valid);
                end
            end
            send(x_words[k]);
            m_x[k] = x_words[k];
        end
        tests++;
        if (vec_valid !== 1'b1) begin
            fails++;
            $display("FAIL vv_latency: vec_valid=%0b required 1", vec_valid);
        end
        tests++;
        if (weights !== 64'h0807060504030201 || biases !== 16'h1110
            || in_vec !== 32'hF3F2F1F0) begin
            fails++;
            $display("FAIL full_buses: w=%h b=%h x=%h required 0807060504030201 1110 f3f2f1f0",
                     weights, biases, in_vec);
        end
        check_buses("full_model");
    endtask

    task automatic test_input_only();
        logic [7:0] x_words [IN_N] = '{8'h7F, 8'h80, 8'h00, 8'h01};
        ack();
        tests++;
        if (vec_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ack_release: vv=%0b busy=%0b required 0 0", vec_valid, busy);
        end
        do_start(1'b0);
        for (int k = 0; k < IN_N; k++) begin
            send(x_words[k]);
            m_x[k] = x_words[k];
        end
        tests++;
        if (in_vec !== 32'h0100807F) begin
            fails++;
            $display("FAIL inonly_vec: x=%h required 0100807f", in_vec);
        end
        check_buses("inonly_model");
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (vec_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: vv=%0b rdy=%0b required 1 0", i, vec_valid, in_ready);
            end
        end
        ack();
    endtask

    task automatic test_backpressure();
        int p = 0;
        logic [NW*DW-1:0] sw;
        logic [OUT_N*DW-1:0] sb;
        logic [IN_N*DW-1:0] sx;
        logic [7:0] words [NW+OUT_N+IN_N] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                             8'h07, 8'h08, 8'h10, 8'h11, 8'hF0, 8'hF1,
                                             8'hF2, 8'hF3};
        do_start(1'b1);
        m_pv = 1'b0;
        for (int i = 0; i < NW + OUT_N + IN_N; i++) begin
            // Valid pattern 1,0,0,1 repeating.
            while ((p % 4) == 1 || (p % 4) == 2) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                sw = weights;
                sb = biases;
                sx = in_vec;
                tick();
                tests++;
                if (weights !== sw || biases !== sb || in_vec !== sx || in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL gap_stall_%0d: rdy=%0b bus changed during gap", i, in_ready);
                end
                p++;
            end
            send(words[i]);
            p++;
        end
        for (int k = 0; k < NW; k++) m_w[k] = DW'(k + 1);
        m_b[0] = 8'h10;
        m_b[1] = 8'h11;
        for (int k = 0; k < IN_N; k++) m_x[k] = 8'hF0 + DW'(k);
        m_pv = 1'b1;
        check_buses("gap_final");
        tests++;
        if (vec_valid !== 1'b1) begin
            fails++;
            $display("FAIL gap_vv: vec_valid=%0b required 1", vec_valid);
        end
        ack();
    endtask

    task automatic test_error_start();
        test_reset();
        do_start(1'b0);
        tests++;
        if (start_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse: err=%0b busy=%0b rdy=%0b required 1 0 0",
                     start_err, busy, in_ready);
        end
        tick();
        tests++;
        if (start_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: err=%0b busy=%0b rdy=%0b required 0 0 0",
                     start_err, busy, in_ready);
        end
    endtask

    task automatic test_reset_midload();
        do_start(1'b1);
        for (int k = 0; k < 5; k++) send(8'hA0 + DW'(k));
        tests++;
        if (weights[5*DW-1:0] !== 40'hA4A3A2A1A0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midload_partial: w=%h busy=%0b required ..a4a3a2a1a0 1",
                     weights, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        tests++;
        if ({weights, biases, in_vec, vec_valid, params_valid, in_ready, busy, start_err}
            !== '0) begin
            fails++;
            $display("FAIL midload_reset: w=%h pv=%0b busy=%0b rdy=%0b required all 0",
                     weights, params_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_buses("midload_after");
    endtask

    task automatic test_collision();
        logic [7:0] d;
        do_start(1'b1);
        for (int k = 0; k < NW; k++) begin
            d = 8'($urandom);
            send(d);
            m_w[k] = d;
        end
        // start asserted throughout the bias segment.
        start = 1'b1;
        reload_params = 1'b1;
        for (int k = 0; k < OUT_N; k++) begin
            d = 8'($urandom);
            send(d);
            m_b[k] = d;
        end
        start = 1'b0;
        reload_params = 1'b0;
        m_pv = 1'b1;
        for (int k = 0; k < IN_N; k++) begin
            d = 8'($urandom);
            send(d);
            m_x[k] = d;
        end
        check_buses("coll_sb");
        start = 1'b1;
        reload_params = 1'b1;
        vec_ack = 1'b1;
        tick();
        start = 1'b0;
        reload_params = 1'b0;
        vec_ack = 1'b0;
        tests++;
        if (busy !== 1'b0 || vec_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL coll_hold: busy=%0b vv=%0b rdy=%0b required 0 0 0",
                     busy, vec_valid, in_ready);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || params_valid !== 1'b1) begin
            fails++;
            $display("FAIL coll_idle: busy=%0b pv=%0b required 0 1", busy, params_valid);
        end
    endtask

    task automatic test_random();
        logic reload;
        logic [7:0] d;
        int wait_n;
        for (int f = 0; f < 8; f++) begin
            reload = (!m_pv) || ($urandom_range(0, 1) == 1);
            do_start(reload);
            if (reload) begin
                m_pv = 1'b0;
                for (int k = 0; k < NW + OUT_N; k++) begin
                    while ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        tick();
                    end
                    d = 8'($urandom);
                    send(d);
                    if (k < NW) m_w[k] = d;
                    else m_b[k-NW] = d;
                end
                m_pv = 1'b1;
            end
            for (int k = 0; k < IN_N; k++) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
                d = 8'($urandom);
                send(d);
                m_x[k] = d;
            end
            check_buses($sformatf("rand_frame_%0d", f));
            wait_n = $urandom_range(0, 3);
            for (int i = 0; i < wait_n; i++) tick();
            tests++;
            if (vec_valid !== 1'b1) begin
                fails++;
                $display("FAIL rand_vv_%0d: vec_valid=%0b required 1", f, vec_valid);
            end
            ack();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_load();
        test_input_only();
        test_backpressure();
        test_error_start();
        test_reset_midload();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
